// File: rtl/operand_feeder_pkg.sv
// Shared types and constants for the operand feeder: slot FSM states and the (a, b) pair layout.
package operand_feeder_pkg;

    localparam int OPERAND_WIDTH = 4;

    localparam logic [OPERAND_WIDTH-1:0] PAD_OPERAND = '0;

    typedef enum logic {
        SLOT_A,
        SLOT_B
    } feeder_state_t;

    typedef struct packed {
        logic [OPERAND_WIDTH-1:0] a;
        logic [OPERAND_WIDTH-1:0] b;
    } operand_pair_t;

endpackage

// File: rtl/operand_feeder_if.sv
// Nibble input stream, pair output stream and status for the operand feeder.
interface operand_feeder_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    logic                         flush;
    logic [WIDTH-1:0]             in_data;
    logic                         in_valid;
    logic                         in_last;
    logic                         in_ready;
    logic [WIDTH-1:0]             out_a;
    logic [WIDTH-1:0]             out_b;
    logic                         out_valid;
    logic                         out_ready;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         err_odd;

    modport master (
        output flush, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_a, out_b, out_valid, count, err_odd
    );

    modport slave (
        input  flush, in_data, in_valid, in_last, out_ready,
        output in_ready, out_a, out_b, out_valid, count, err_odd
    );
endinterface

// File: rtl/pair_fifo.sv
// DEPTH-entry pair FIFO, read data straight from the head entry; push+pop while full is legal.
// Flush clears pointers and count next cycle; the caller gates push/pop with its handshakes.
module pair_fifo
    import operand_feeder_pkg::*;
#(
    parameter type T     = operand_pair_t,
    parameter int  DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  T                           wdata,
    output T                           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T                mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;

    assign rdata = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // DEPTH is a power of two, so the pointers wrap on their natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/operand_feeder.sv
// Pairs a nibble stream into (a, b) operands, padding odd bursts with b = 0; pair visible 1 cycle after push.
// in_ready drops only when the FIFO is full and the consumer is not popping, or during flush.
module operand_feeder
    import operand_feeder_pkg::*;
#(
    parameter int WIDTH = OPERAND_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    operand_feeder_if.slave bus
);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    feeder_state_t    state;
    logic [WIDTH-1:0] a_hold;
    logic             err_odd_q;

    logic             full;
    logic             empty;
    logic             accept;
    logic             push;
    logic             pop;
    pair_t            wr_pair;
    pair_t            head;
    logic [CW-1:0]    fifo_count;

    // Ready never looks at in_valid, so upstream can wait on it without a loop.
    assign bus.in_ready  = !bus.flush && (!full || bus.out_ready);
    assign bus.out_valid = !bus.flush && !empty;

    assign accept = bus.in_valid && bus.in_ready;
    assign pop    = bus.out_valid && bus.out_ready;
    assign push   = accept && ((state == SLOT_B) || bus.in_last);

    always_comb begin
        wr_pair = '0;
        if (state == SLOT_B) begin
            wr_pair.a = a_hold;
            wr_pair.b = bus.in_data;
        end else begin
            wr_pair.a = bus.in_data;
            wr_pair.b = WIDTH'(PAD_OPERAND);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SLOT_A;
            a_hold    <= '0;
            err_odd_q <= 1'b0;
        end else if (bus.flush) begin
            state     <= SLOT_A;
            a_hold    <= '0;
            err_odd_q <= 1'b0;
        end else begin
            err_odd_q <= 1'b0;
            if (accept) begin
                if (state == SLOT_B) begin
                    state <= SLOT_A;
                end else if (bus.in_last) begin
                    err_odd_q <= 1'b1;
                end else begin
                    a_hold <= bus.in_data;
                    state  <= SLOT_B;
                end
            end
        end
    end

    pair_fifo #(
        .T     (pair_t),
        .DEPTH (DEPTH)
    ) u_pair_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.flush),
        .push  (push),
        .pop   (pop),
        .wdata (wr_pair),
        .rdata (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign bus.out_a   = head.a;
    assign bus.out_b   = head.b;
    assign bus.count   = fifo_count;
    assign bus.err_odd = err_odd_q;

endmodule

// File: tb/tb_operand_feeder.sv
// Randomized and directed bench for operand_feeder against a queue-based pairing model.
module tb_operand_feeder;
    localparam int W = 4;
    localparam int D = 4;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pr_t;

    logic clk = 1'b0;
    logic rst_n;

    operand_feeder_if #(.WIDTH(W), .DEPTH(D)) bus ();

    operand_feeder #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    pr_t          mq[$];
    logic         pend;
    logic [W-1:0] pend_a;
    logic         exp_err;
    int           vecs = 0;
    int           errs = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        pend    = 1'b0;
        pend_a  = '0;
        exp_err = 1'b0;
    endtask

    // One clock cycle: drive, check at negedge, advance the model, return 1 time unit after posedge.
    task automatic step(input logic fl, input logic v, input logic l, input logic r,
                        input logic [W-1:0] d);
        logic exp_rdy, exp_vld, acc, pop;
        bus.flush     = fl;
        bus.in_valid  = v;
        bus.in_last   = l;
        bus.out_ready = r;
        bus.in_data   = d;
        @(negedge clk);
        exp_rdy = !fl && ((mq.size() != D) || r);
        exp_vld = !fl && (mq.size() != 0);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(exp_vld));
        chk("count", 32'(bus.count), 32'(mq.size()));
        chk("err_odd", 32'(bus.err_odd), 32'(exp_err));
        if (mq.size() != 0) begin
            chk("out_a", 32'(bus.out_a), 32'(mq[0].a));
            chk("out_b", 32'(bus.out_b), 32'(mq[0].b));
        end
        if (fl) begin
            model_clear();
        end else begin
            acc     = v && exp_rdy;
            pop     = exp_vld && r;
            exp_err = 1'b0;
            if (pop) void'(mq.pop_front());
            if (acc) begin
                if (pend) begin
                    mq.push_back(pr_t'{a: pend_a, b: d});
                    pend = 1'b0;
                end else if (l) begin
                    mq.push_back(pr_t'{a: d, b: '0});
                    exp_err = 1'b1;
                end else begin
                    pend_a = d;
                    pend   = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic l, input logic r);
        step(1'b0, 1'b1, l, r, d);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, r, '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_count"}, 32'(bus.count), 32'd0);
        chk({tag, "_out_a"}, 32'(bus.out_a), 32'd0);
        chk({tag, "_out_b"}, 32'(bus.out_b), 32'd0);
        chk({tag, "_err_odd"}, 32'(bus.err_odd), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_clear();
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic pairing with consumer always ready
        send(4'd3, 1'b0, 1'b1);
        send(4'd5, 1'b0, 1'b1);
        chk("pair35_vld", 32'(bus.out_valid), 32'd1);
        chk("pair35_a", 32'(bus.out_a), 32'd3);
        chk("pair35_b", 32'(bus.out_b), 32'd5);
        send(4'd9, 1'b0, 1'b1);
        send(4'd7, 1'b0, 1'b1);
        chk("pair97_a", 32'(bus.out_a), 32'd9);
        chk("pair97_b", 32'(bus.out_b), 32'd7);
        idle(2, 1'b1);

        // Odd burst padded with b = 0
        send(4'd6, 1'b0, 1'b1);
        send(4'd2, 1'b0, 1'b1);
        send(4'd4, 1'b1, 1'b1);
        chk("odd_err", 32'(bus.err_odd), 32'd1);
        chk("odd_a", 32'(bus.out_a), 32'd4);
        chk("odd_b", 32'(bus.out_b), 32'd0);
        idle(1, 1'b1);
        chk("odd_err_once", 32'(bus.err_odd), 32'd0);
        idle(2, 1'b1);

        // Fill to full under backpressure, then push+pop at full via a padded nibble
        for (int i = 0; i < 10; i++) send(W'(i + 1), 1'b0, 1'b0);
        chk("full_count", 32'(bus.count), 32'(D));
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        send(4'hE, 1'b1, 1'b1);
        chk("full_pushpop_count", 32'(bus.count), 32'(D));
        for (int i = 0; i < 6; i++) send(W'(i + 10), 1'b0, 1'b1);
        idle(6, 1'b1);

        // Flush with a pair buffered and a partial operand held
        send(4'd1, 1'b0, 1'b0);
        send(4'd2, 1'b0, 1'b0);
        send(4'd3, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd5);
        chk("flush_count", 32'(bus.count), 32'd0);
        send(4'd8, 1'b0, 1'b0);
        send(4'd9, 1'b0, 1'b0);
        chk("flush_pair_a", 32'(bus.out_a), 32'd8);
        chk("flush_pair_b", 32'(bus.out_b), 32'd9);
        idle(3, 1'b1);

        // Asynchronous reset mid-operation: 2 pairs buffered and a held a operand
        for (int i = 0; i < 5; i++) send(W'(i + 1), 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(4'hA, 1'b0, 1'b0);
        send(4'hB, 1'b0, 1'b0);
        chk("arst_pair_a", 32'(bus.out_a), 32'hA);
        chk("arst_pair_b", 32'(bus.out_b), 32'hB);
        idle(2, 1'b1);

        // Randomized traffic with bursty backpressure and occasional flush
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 5) == 0),
                 (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 W'($urandom_range(0, 15)));
        end
        idle(8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
